song_player_pwm: RTL and testbench
==================================

// Module: song_player_pwm
// PURPOSE
//  Playback stage around the song sample BRAM: generates play_addr at the sample rate,
//  captures the signed 8-bit sample after the fixed memory read latency, converts it to
//  offset binary and drives a 1-bit 256-step PWM audio output. Play/pause/restart/loop control.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency
//  SAMPLE_HZ     8_000       sample rate; TICK_DIV = CLK_HZ/SAMPLE_HZ, must be > READ_LATENCY+1
//  ADDR_W        16          play_addr width
//  SONG_LEN      65536       samples in song, 2..2**ADDR_W
//  READ_LATENCY  3           clock edges from play_addr update until sample_in reflects it
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  play        in   1       level: 1 = run, 0 = pause
//  restart     in   1       1-cycle pulse: rewind to address 0, go IDLE
//  loop_en     in   1       1 = wrap to 0 at end of song, 0 = stop (DONE)
//  sample_in   in   8s      signed sample from memory for play_addr (READ_LATENCY later)
//  play_addr   out  ADDR_W  sample address to memory (registered)
//  pwm_out     out  1       PWM audio bit (registered)
//  playing     out  1       state == PLAY
//  done        out  1       1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, play_addr=0, tick_cnt=0, lat_cnt=0, sample_q=8'h80,
//   duty_q=8'h80, pwm_cnt=0, pwm_out=0, done=0.
//  States: IDLE, PLAY, PAUSE, DONE.
//   IDLE : play=1 -> PLAY; loads lat_cnt=READ_LATENCY+1 (fetch addr 0), tick_cnt=0.
//   PLAY : tick_cnt increments; at tick_cnt==TICK_DIV-1 (tick): tick_cnt<=0 and
//          play_addr==SONG_LEN-1: loop_en ? play_addr<=0 : (state<=DONE, done=1, addr held);
//          else play_addr<=play_addr+1. Every addr change loads lat_cnt=READ_LATENCY+1.
//          play=0 -> PAUSE (a tick in the same cycle is still taken).
//   PAUSE: tick_cnt, play_addr held; play=1 -> PLAY, tick_cnt resumes from held value.
//   DONE : addr held, sample_q<=8'h80; leaves only via restart.
//  restart (highest priority, any state): play_addr<=0, tick_cnt<=0, lat_cnt<=0,
//   sample_q<=8'h80, state<=IDLE; done not asserted. Re-enters PLAY next cycle if play=1.
//  Sample capture: lat_cnt decrements every edge while nonzero (all states); at the edge
//   where lat_cnt==1: sample_q <= sample_in ^ 8'h80 (signed -> offset binary).
//   -128 -> 0x00, 0 -> 0x80, +127 -> 0xFF. Reload while counting restarts the count.
//  PWM: pwm_cnt 8-bit free-running in all states, wraps 255->0. duty_q <= sample_q only on
//   the edge where pwm_cnt==255 (glitch-free period boundary). pwm_out <= (pwm_cnt < duty_q).
//   Duty 0x00 -> constant 0; 0xFF -> high 255 of 256 cycles; 0x80 -> 128/256.
//  Sample-to-PWM latency: <= READ_LATENCY+1 edges capture + <=256 edges to duty + 1 edge.
//  playing is combinational from state register; done is registered, exactly 1 cycle.
// TESTING (CLK_HZ=1000, SAMPLE_HZ=100 -> TICK_DIV=10; SONG_LEN=4; bench memory model with
//  3-cycle latency, mem[a] = {8'sh80, 8'sh00, 8'sh7F, 8'sh40}[a])
//  1 reset_n=0 mid-PLAY -> immediately play_addr=0, pwm_out=0, playing=0; after release
//    duty_q=0x80 and pwm_out high 128 of every 256 cycles.
//  2 play=1, loop_en=0 -> play_addr 0,1,2,3 each held 10 cycles; sample_q 0x00,0x80,0xFF,0xC0
//    captured 4 edges after each addr change; done high 1 cycle on tick at addr 3; DONE, addr=3.
//  3 loop_en=1, run 12 ticks -> play_addr sequence 0,1,2,3,0,1,2,3,0,... no done pulse.
//  4 play=0 for 25 cycles at tick_cnt=6, addr=2 -> addr/tick_cnt frozen; resume -> next
//    addr change exactly 3 cycles after play returns high.
//  5 restart pulse same cycle as tick at addr 1 -> play_addr=0 (restart wins), IDLE then PLAY.
//  6 sample_q changes mid PWM period -> pwm_out duty changes only after pwm_cnt 255->0 boundary.

Source files
------------

// File: rtl/song_player_pwm_if.sv
// Signal bundle of the song playback stage: transport control, sample memory port,
// audio output and debug taps. There is no valid/ready handshake: play and loop_en
// are levels, restart is a single-cycle pulse, and sample_in is a fixed-latency read.
interface song_player_pwm_if #(
  parameter int ADDR_W = 16
);
  logic              play;
  logic              restart;
  logic              loop_en;
  logic signed [7:0] sample_in;
  logic [ADDR_W-1:0] play_addr;
  logic              pwm_out;
  logic              playing;
  logic              done;
  logic [1:0]        dbg_state;
  logic [31:0]       dbg_tick_cnt;
  logic [7:0]        dbg_sample_q;
  logic [7:0]        dbg_duty_q;

  modport master (
    output play, restart, loop_en, sample_in,
    input  play_addr, pwm_out, playing, done,
    input  dbg_state, dbg_tick_cnt, dbg_sample_q, dbg_duty_q
  );

  modport slave (
    input  play, restart, loop_en, sample_in,
    output play_addr, pwm_out, playing, done,
    output dbg_state, dbg_tick_cnt, dbg_sample_q, dbg_duty_q
  );
endinterface

// File: rtl/song_player_pwm.sv
// Song playback: steps the sample address at the sample rate, captures the memory
// sample after its read latency, converts it to offset binary and drives a 256-step PWM.
module song_player_pwm #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SAMPLE_HZ    = 8_000,
  parameter int ADDR_W       = 16,
  parameter int SONG_LEN     = 65536,
  parameter int READ_LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  song_player_pwm_if.slave bus
);
  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LAT_W    = $clog2(READ_LATENCY + 2);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [ADDR_W-1:0] r_play_addr;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [7:0]        r_sample_q;
  logic [7:0]        r_duty_q;
  logic [7:0]        r_pwm_cnt;
  logic              r_pwm_out;
  logic              r_done;

  logic w_run;
  logic w_tick;
  logic w_at_end;
  logic w_song_end;
  logic w_addr_step;
  logic w_start;
  logic w_lat_load;

  // The resume edge out of PAUSE already counts, so the divider never loses a cycle.
  assign w_run       = (r_state == S_PLAY) || ((r_state == S_PAUSE) && bus.play);
  assign w_tick      = w_run && (r_tick_cnt == TICK_LAST);
  assign w_at_end    = (r_play_addr == ADDR_LAST);
  assign w_song_end  = w_tick && w_at_end && !bus.loop_en;
  assign w_addr_step = w_tick && !w_song_end;
  assign w_start     = (r_state == S_IDLE) && bus.play;
  assign w_lat_load  = w_start || w_addr_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.play) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (w_song_end)     w_state_nxt = S_DONE;
        else if (!bus.play) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_song_end)    w_state_nxt = S_DONE;
        else if (bus.play) w_state_nxt = S_PLAY;
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (bus.restart) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt  <= '0;
      r_play_addr <= '0;
    end else if (bus.restart) begin
      r_tick_cnt  <= '0;
      r_play_addr <= '0;
    end else begin
      if (w_start || w_tick) begin
        r_tick_cnt <= '0;
      end else if (w_run) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      if (w_addr_step) begin
        r_play_addr <= w_at_end ? '0 : r_play_addr + 1'b1;
      end
    end
  end

  // lat_cnt reaches 1 on the first edge where sample_in reflects the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_cnt <= '0;
    end else if (bus.restart) begin
      r_lat_cnt <= '0;
    end else if (w_lat_load) begin
      r_lat_cnt <= LAT_LOAD;
    end else if (r_lat_cnt != '0) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample_q <= 8'h80;
    end else if (bus.restart || (r_state == S_DONE)) begin
      r_sample_q <= 8'h80;
    end else if (r_lat_cnt == LAT_ONE) begin
      r_sample_q <= {~bus.sample_in[7], bus.sample_in[6:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_song_end && !bus.restart;
    end
  end

  // Duty only moves at the period boundary so a period never mixes two samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_duty_q  <= 8'h80;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == 8'hFF) r_duty_q <= r_sample_q;
      r_pwm_out <= (r_pwm_cnt < r_duty_q);
    end
  end

  assign bus.play_addr    = r_play_addr;
  assign bus.pwm_out      = r_pwm_out;
  assign bus.playing      = (r_state == S_PLAY);
  assign bus.done         = r_done;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_tick_cnt = 32'(r_tick_cnt);
  assign bus.dbg_sample_q = r_sample_q;
  assign bus.dbg_duty_q   = r_duty_q;
endmodule

// File: tb/tb_song_player_pwm.sv
// Directed bench for song_player_pwm: TICK_DIV=10, SONG_LEN=4, 3-cycle memory model.
module tb_song_player_pwm;
  localparam int ADDR_W = 16;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  song_player_pwm_if #(.ADDR_W(ADDR_W)) bus ();

  song_player_pwm #(
    .CLK_HZ      (1000),
    .SAMPLE_HZ   (100),
    .ADDR_W      (ADDR_W),
    .SONG_LEN    (4),
    .READ_LATENCY(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: sample_in reflects play_addr three edges after it changes
  logic [7:0]        mem     [4];
  logic [7:0]        exp_off [4];
  logic [ADDR_W-1:0] a1 = '0;
  logic [ADDR_W-1:0] a2 = '0;
  logic [ADDR_W-1:0] a3 = '0;
  always @(posedge clk) begin
    a1 <= bus.play_addr;
    a2 <= a1;
    a3 <= a2;
  end
  always_comb bus.sample_in = mem[a3[1:0]];

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  sq;
    logic        done;
    logic [1:0]  st;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // restart pulse with play held high: IDLE for one cycle, then PLAY (cycle 0)
  task automatic restart_and_start();
    bus.restart = 1'b1;
    bus.play    = 1'b1;
    tick_clk(1);
    check("restart_state", bus.dbg_state, ST_IDLE);
    check("restart_addr", bus.play_addr, 0);
    check("restart_no_done", bus.done, 0);
    bus.restart = 1'b0;
    tick_clk(1);
    check("start_state", bus.dbg_state, ST_PLAY);
  endtask

  initial begin
    int cur;
    int highs;
    logic done_seen;

    mem[0] = 8'h80; mem[1] = 8'h00; mem[2] = 8'h7F; mem[3] = 8'h40;
    exp_off[0] = 8'h00; exp_off[1] = 8'h80; exp_off[2] = 8'hFF; exp_off[3] = 8'hC0;

    vecs[0]  = '{0,  16'd0, 8'h80, 1'b0, ST_PLAY};
    vecs[1]  = '{3,  16'd0, 8'h80, 1'b0, ST_PLAY};
    vecs[2]  = '{4,  16'd0, 8'h00, 1'b0, ST_PLAY};
    vecs[3]  = '{9,  16'd0, 8'h00, 1'b0, ST_PLAY};
    vecs[4]  = '{10, 16'd1, 8'h00, 1'b0, ST_PLAY};
    vecs[5]  = '{13, 16'd1, 8'h00, 1'b0, ST_PLAY};
    vecs[6]  = '{14, 16'd1, 8'h80, 1'b0, ST_PLAY};
    vecs[7]  = '{20, 16'd2, 8'h80, 1'b0, ST_PLAY};
    vecs[8]  = '{24, 16'd2, 8'hFF, 1'b0, ST_PLAY};
    vecs[9]  = '{30, 16'd3, 8'hFF, 1'b0, ST_PLAY};
    vecs[10] = '{34, 16'd3, 8'hC0, 1'b0, ST_PLAY};
    vecs[11] = '{39, 16'd3, 8'hC0, 1'b0, ST_PLAY};
    vecs[12] = '{40, 16'd3, 8'hC0, 1'b1, ST_DONE};
    vecs[13] = '{41, 16'd3, 8'h80, 1'b0, ST_DONE};
    vecs[14] = '{70, 16'd3, 8'h80, 1'b0, ST_DONE};

    bus.play    = 1'b0;
    bus.restart = 1'b0;
    bus.loop_en = 1'b0;

    // reset state
    reset_n = 1'b0;
    tick_clk(3);
    check("rst_addr", bus.play_addr, 0);
    check("rst_pwm", bus.pwm_out, 0);
    check("rst_playing", bus.playing, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    check("rst_sample", bus.dbg_sample_q, 8'h80);
    check("rst_duty", bus.dbg_duty_q, 8'h80);
    check("rst_tick", bus.dbg_tick_cnt, 0);
    reset_n = 1'b1;
    tick_clk(2);
    check("idle_hold", bus.dbg_state, ST_IDLE);

    // one pass through the song without looping
    bus.play    = 1'b1;
    bus.loop_en = 1'b0;
    tick_clk(1);
    cur = 0;
    for (int i = 0; i < 15; i++) begin
      tick_clk(vecs[i].cyc - cur);
      cur = vecs[i].cyc;
      check("once_addr", bus.play_addr, vecs[i].addr);
      check("once_sample", bus.dbg_sample_q, vecs[i].sq);
      check("once_done", bus.done, vecs[i].done);
      check("once_state", bus.dbg_state, vecs[i].st);
      check("once_playing", bus.playing, vecs[i].st == ST_PLAY);
    end

    // looping: 12 ticks, address wraps and no done pulse
    bus.loop_en = 1'b1;
    restart_and_start();
    done_seen = 1'b0;
    for (int c = 0; c < 125; c++) begin
      if (c > 0) tick_clk(1);
      check("loop_addr", bus.play_addr, (c / 10) % 4);
      if (c % 10 == 4) check("loop_sample", bus.dbg_sample_q, exp_off[(c / 10) % 4]);
      if (bus.done) done_seen = 1'b1;
    end
    check("loop_no_done", done_seen, 0);

    // pause at addr 2 / tick_cnt 6 for 25 cycles, then resume
    restart_and_start();
    tick_clk(26);
    check("pause_pre_addr", bus.play_addr, 2);
    check("pause_pre_tick", bus.dbg_tick_cnt, 6);
    bus.play = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick_clk(1);
      check("pause_state", bus.dbg_state, ST_PAUSE);
      check("pause_addr", bus.play_addr, 2);
      check("pause_tick", bus.dbg_tick_cnt, 7);
    end
    bus.play = 1'b1;
    tick_clk(1);
    check("resume1_state", bus.dbg_state, ST_PLAY);
    check("resume1_addr", bus.play_addr, 2);
    tick_clk(1);
    check("resume2_addr", bus.play_addr, 2);
    check("resume2_tick", bus.dbg_tick_cnt, 9);
    tick_clk(1);
    check("resume3_addr", bus.play_addr, 3);
    check("resume3_tick", bus.dbg_tick_cnt, 0);
    tick_clk(4);
    check("resume_sample", bus.dbg_sample_q, 8'hC0);

    // restart coinciding with the tick at addr 1
    restart_and_start();
    tick_clk(19);
    check("rs_pre_addr", bus.play_addr, 1);
    check("rs_pre_tick", bus.dbg_tick_cnt, 9);
    bus.restart = 1'b1;
    tick_clk(1);
    check("rs_addr", bus.play_addr, 0);
    check("rs_state", bus.dbg_state, ST_IDLE);
    check("rs_tick", bus.dbg_tick_cnt, 0);
    check("rs_playing", bus.playing, 0);
    check("rs_done", bus.done, 0);
    bus.restart = 1'b0;
    tick_clk(1);
    check("rs_replay_state", bus.dbg_state, ST_PLAY);
    check("rs_replay_addr", bus.play_addr, 0);
    tick_clk(3);
    check("rs_sample_wait", bus.dbg_sample_q, 8'h80);
    tick_clk(1);
    check("rs_sample_cap", bus.dbg_sample_q, 8'h00);

    // asynchronous reset in the middle of playback
    tick_clk(21);
    check("ar_pre_addr", bus.play_addr, 2);
    check("ar_pre_sample", bus.dbg_sample_q, 8'hFF);
    #2;
    reset_n  = 1'b0;
    bus.play = 1'b0;
    #1;
    check("ar_addr", bus.play_addr, 0);
    check("ar_pwm", bus.pwm_out, 0);
    check("ar_playing", bus.playing, 0);
    check("ar_sample", bus.dbg_sample_q, 8'h80);
    check("ar_duty", bus.dbg_duty_q, 8'h80);
    tick_clk(2);
    check("ar_hold_state", bus.dbg_state, ST_IDLE);
    reset_n = 1'b1;

    // PWM: 50% after reset, then a sample change mid-period takes effect at the boundary
    highs = 0;
    for (int n = 1; n <= 768; n++) begin
      tick_clk(1);
      if (bus.pwm_out) highs++;
      if (n == 256) begin
        check("pwm_reset_duty", highs, 128);
        highs = 0;
      end
      if (n == 481) begin
        bus.play    = 1'b1;
        bus.loop_en = 1'b1;
      end
      if (n == 506) begin
        check("pwm_mid_sample", bus.dbg_sample_q, 8'hFF);
        check("pwm_mid_duty", bus.dbg_duty_q, 8'h80);
      end
      if (n == 512) begin
        check("pwm_old_period", highs, 128);
        check("pwm_new_duty", bus.dbg_duty_q, 8'hFF);
        highs = 0;
      end
      if (n == 768) check("pwm_new_period", highs, 255);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
